aes_cipher_iter: RTL and testbench

//   Iterative AES forward cipher (encryption), the companion of the inverse cipher: one round per clock,

---
 rtl/aes_cipher_iter_pkg.sv | 90 +++++++++
 rtl/aes_cipher_iter_round.sv | 27 ++
 rtl/aes_cipher_iter.sv | 108 ++++++++++
 tb/tb_aes_cipher_iter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_cipher_iter_pkg.sv
// ----------------------------------------------------------------------------
// aes_cipher_iter_pkg
//   Shared definitions for the iterative AES forward cipher: block geometry,
//   the key-size table (Nk -> Nr), the FSM state encoding and the combinational
//   round transformations (SubBytes, ShiftRows, MixColumns, AddRoundKey).
//   State byte i (column-major, i = row + 4*col) lives at [127-8*i -: 8].
// ----------------------------------------------------------------------------
package aes_cipher_iter_pkg;

    localparam int Nb         = 4;
    localparam int WORD_SIZE  = 32;
    localparam int BLOCK_SIZE = Nb * WORD_SIZE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_e;

    // Legal key sizes map to their round counts; anything else returns 0 so an
    // elaboration check can reject it.
    function automatic int roundsForKey(input int nk);
        case (nk)
            4:       return 10;
            6:       return 12;
            8:       return 14;
            default: return 0;
        endcase
    endfunction

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [127:0] subBytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[127-8*i -: 8] = SBOX[s[127-8*i -: 8]];
        end
        return r;
    endfunction

    // Row r rotates left by r columns: out[r][c] = in[r][(c+r) mod 4].
    function automatic logic [127:0] shiftRows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int row = 0; row < 4; row++) begin
            for (int col = 0; col < 4; col++) begin
                r[127-8*(row+4*col) -: 8] = s[127-8*(row+4*((col+row)%4)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] mixColumns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int col = 0; col < 4; col++) begin
            a0 = s[127-32*col -: 8];
            a1 = s[119-32*col -: 8];
            a2 = s[111-32*col -: 8];
            a3 = s[103-32*col -: 8];
            // 3*x is xtime(x)^x, so each row is built from xtime terms plus plain bytes.
            r[127-32*col -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*col -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*col -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*col -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    function automatic logic [127:0] addRoundKey(input logic [127:0] s, input logic [127:0] k);
        return s ^ k;
    endfunction

endpackage

// File: rtl/aes_cipher_iter_round.sv
// ----------------------------------------------------------------------------
// aes_cipher_iter_round
//   One combinational AES encryption round:
//   SubBytes -> ShiftRows -> [MixColumns] -> AddRoundKey.
//   Ports:
//     state_i       128  state entering the round
//     key_i         128  round key for this round
//     final_round_i 1    bypass MixColumns (last round)
//     state_o       128  state leaving the round
// ----------------------------------------------------------------------------
module aes_cipher_iter_round
    import aes_cipher_iter_pkg::*;
(
    input  logic [BLOCK_SIZE-1:0] state_i,
    input  logic [BLOCK_SIZE-1:0] key_i,
    input  logic                  final_round_i,
    output logic [BLOCK_SIZE-1:0] state_o
);

    logic [BLOCK_SIZE-1:0] shifted;
    logic [BLOCK_SIZE-1:0] mixed;

    assign shifted = shiftRows(subBytes(state_i));
    assign mixed   = mixColumns(shifted);
    assign state_o = addRoundKey(final_round_i ? shifted : mixed, key_i);

endmodule

// File: rtl/aes_cipher_iter.sv
// ----------------------------------------------------------------------------
// aes_cipher_iter
//   Iterative AES forward cipher, one round per clock, valid/ready on both sides.
//   Ports:
//     clk, reset       clock, asynchronous active-high reset
//     in_valid/ready   plaintext handshake; in = plaintext (byte 0 in [127:120])
//     round_keys       expanded keys, round r at [128*r +: 128]; must stay stable
//                      from accept until the output handshake
//     out_valid/ready  ciphertext handshake; out = ciphertext, zero when not valid
//     busy             a block is in flight or waiting to be taken
// ----------------------------------------------------------------------------
module aes_cipher_iter
    import aes_cipher_iter_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [BLOCK_SIZE-1:0]       in,
    input  logic [BLOCK_SIZE*(Nr+1)-1:0] round_keys,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [BLOCK_SIZE-1:0]       out,
    output logic                        busy
);

    localparam int          ROUND_KEYS_SIZE = BLOCK_SIZE * (Nr + 1);
    localparam logic [3:0]  LAST_ROUND      = 4'(Nr);

    if (Nr != roundsForKey(Nk)) begin : gBadRounds
        $error("aes_cipher_iter: Nr=%0d does not match Nk=%0d", Nr, Nk);
    end

    fsm_e                  fsm_q;
    logic [3:0]            round_q;
    logic [BLOCK_SIZE-1:0] state_q;
    logic [BLOCK_SIZE-1:0] roundKey [Nr+1];
    logic [BLOCK_SIZE-1:0] roundOut;
    logic                  finalRound;
    logic                  accept;

    for (genvar g = 0; g < ROUND_KEYS_SIZE / BLOCK_SIZE; g++) begin : gKeys
        assign roundKey[g] = round_keys[BLOCK_SIZE*g +: BLOCK_SIZE];
    end

    assign finalRound = (round_q == LAST_ROUND);

    aes_cipher_iter_round uRound (
        .state_i       (state_q),
        .key_i         (roundKey[round_q]),
        .final_round_i (finalRound),
        .state_o       (roundOut)
    );

    // A result leaving DONE frees the slot in the same cycle, so in_ready
    // looks through to out_ready for back-to-back blocks.
    assign in_ready  = (fsm_q == IDLE) || ((fsm_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (fsm_q == DONE);
    assign out       = out_valid ? state_q : '0;
    assign busy      = (fsm_q == RUN) || (fsm_q == DONE);

    // Whole datapath state: the FSM, the round counter and the AES state.
    // In DONE the counter stays at Nr until the block leaves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q   <= IDLE;
            round_q <= '0;
            state_q <= '0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= addRoundKey(in, roundKey[0]);
                        round_q <= 4'd1;
                        fsm_q   <= RUN;
                    end
                end
                RUN: begin
                    state_q <= roundOut;
                    if (finalRound) begin
                        fsm_q <= DONE;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                DONE: begin
                    if (accept) begin
                        state_q <= addRoundKey(in, roundKey[0]);
                        round_q <= 4'd1;
                        fsm_q   <= RUN;
                    end else if (out_ready) begin
                        round_q <= '0;
                        fsm_q   <= IDLE;
                    end
                end
                default: begin
                    round_q <= '0;
                    fsm_q   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_cipher_iter.sv
// ----------------------------------------------------------------------------
// tb_aes_cipher_iter
//   Directed known-answer bench for the iterative AES cipher. Round keys come
//   from a key-expansion model built here with its own arithmetic S-box; the
//   ciphertexts are published AES-128/AES-256 answers.
// ----------------------------------------------------------------------------
module tb_aes_cipher_iter;

    logic           clk = 1'b0;
    logic           reset;

    logic           inValidA, inReadyA, outValidA, outReadyA, busyA;
    logic [127:0]   inA, outA;
    logic [1407:0]  rkA;

    logic           inValidB, inReadyB, outValidB, outReadyB, busyB;
    logic [127:0]   inB, outB;
    logic [1919:0]  rkB;

    logic [1919:0]  rkFull;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] KEY_APPB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_APPB  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_APPB  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] KEY_C3   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C3    = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic [127:0] bbPt [4];
    logic [127:0] bbCt [4];

    // Free-running 100 MHz clock shared by both cipher instances.
    always #5 clk = ~clk;

    aes_cipher_iter #(.Nk(4), .Nr(10)) dutA (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (inValidA),
        .in_ready   (inReadyA),
        .in         (inA),
        .round_keys (rkA),
        .out_valid  (outValidA),
        .out_ready  (outReadyA),
        .out        (outA),
        .busy       (busyA)
    );

    aes_cipher_iter #(.Nk(8), .Nr(14)) dutB (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (inValidB),
        .in_ready   (inReadyB),
        .in         (inB),
        .round_keys (rkB),
        .out_valid  (outValidB),
        .out_ready  (outReadyB),
        .out        (outB),
        .busy       (busyB)
    );

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse (x^254) then affine map.
    function automatic logic [7:0] modelSbox(input logic [7:0] x);
        logic [7:0] inv, s, rot;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        s = inv; rot = inv;
        for (int i = 0; i < 4; i++) begin
            rot = {rot[6:0], rot[7]};
            s = s ^ rot;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {modelSbox(w[31:24]), modelSbox(w[23:16]), modelSbox(w[15:8]), modelSbox(w[7:0])};
    endfunction

    // Key expansion; key is left-aligned in 256 bits, round r lands at [128*r +: 128].
    function automatic logic [1919:0] expandKey(input logic [255:0] key, input int nk);
        logic [31:0]   w [60];
        logic [31:0]   temp;
        logic [7:0]    rcon;
        logic [1919:0] rk;
        int            total;
        rk = '0; rcon = 8'h01; total = 4 * (nk + 7);
        for (int i = 0; i < 60; i++) w[i] = 32'h0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < total; i++) begin
            temp = w[i-1];
            if (i % nk == 0) begin
                temp = subWord({temp[23:0], temp[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                temp = subWord(temp);
            end
            w[i] = w[i-nk] ^ temp;
        end
        for (int r = 0; r < total / 4; r++)
            for (int c = 0; c < 4; c++)
                rk[128*r + 32*(3-c) +: 32] = w[4*r+c];
        return rk;
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Push one block into dutA with out_ready high, check latency and result.
    // With noise set, in_valid toggles with garbage on in during the first rounds.
    task automatic applyStimulus(input logic [127:0] pt, input logic [127:0] expCt,
                                 input bit noise, input string tag);
        int cycles;
        @(negedge clk);
        inA = pt; inValidA = 1'b1;
        checkOutput({tag, "_inReady"}, 128'(inReadyA), 128'd1);
        @(negedge clk);
        inValidA = 1'b0; inA = '0;
        checkOutput({tag, "_busy"}, 128'(busyA), 128'd1);
        checkOutput({tag, "_noLeak"}, outA, 128'd0);
        cycles = 0;
        while (!outValidA && cycles < 40) begin
            if (noise && cycles < 8) begin
                inValidA = cycles[0];
                inA = {$urandom(), $urandom(), $urandom(), $urandom()};
            end else begin
                inValidA = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        inValidA = 1'b0;
        checkOutput({tag, "_latency"}, 128'(cycles), 128'd10);
        checkOutput({tag, "_out"}, outA, expCt);
        @(negedge clk);
        checkOutput({tag, "_released"}, 128'(outValidA), 128'd0);
    endtask

    // Main sequence of directed scenarios.
    initial begin
        int cycles, acc, outs, cyc;
        int accAt [4];

        bbPt[0] = 128'h6bc1bee22e409f96e93d7e117393172a; bbCt[0] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
        bbPt[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51; bbCt[1] = 128'hf5d3d58503b9699de785895a96fdbaaf;
        bbPt[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef; bbCt[2] = 128'h43b1cd7f598ece23881b00e3ed030688;
        bbPt[3] = 128'hf69f2445df4f9b17ad2b417be66c3710; bbCt[3] = 128'h7b0c785e27e8ad3f8223207104725dd4;

        reset = 1'b1;
        inValidA = 1'b0; inA = '0; outReadyA = 1'b1;
        inValidB = 1'b0; inB = '0; outReadyB = 1'b1;
        rkFull = expandKey({KEY_APPB, 128'h0}, 4); rkA = rkFull[1407:0];
        rkFull = expandKey(KEY_C3, 8);             rkB = rkFull;

        repeat (3) @(negedge clk);
        checkOutput("rst_outValid", 128'(outValidA), 128'd0);
        checkOutput("rst_out", outA, 128'd0);
        checkOutput("rst_busy", 128'(busyA), 128'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_inReady", 128'(inReadyA), 128'd1);

        applyStimulus(PT_APPB, CT_APPB, 1'b0, "appB");

        rkFull = expandKey({KEY_C1, 128'h0}, 4); rkA = rkFull[1407:0];
        applyStimulus(PT_C, CT_C1, 1'b0, "c1");

        // AES-256 instance: 14-clock latency.
        @(negedge clk);
        inB = PT_C; inValidB = 1'b1;
        @(negedge clk);
        inValidB = 1'b0;
        cycles = 0;
        while (!outValidB && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("c3_latency", 128'(cycles), 128'd14);
        checkOutput("c3_out", outB, CT_C3);

        // Backpressure: the result must sit still while out_ready is low.
        rkFull = expandKey({KEY_APPB, 128'h0}, 4); rkA = rkFull[1407:0];
        outReadyA = 1'b0;
        @(negedge clk);
        inA = PT_APPB; inValidA = 1'b1;
        @(negedge clk);
        inValidA = 1'b0;
        cycles = 0;
        while (!outValidA && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("bp_latency", 128'(cycles), 128'd10);
        for (int i = 0; i < 20; i++) begin
            checkOutput("bp_outValid", 128'(outValidA), 128'd1);
            checkOutput("bp_out", outA, CT_APPB);
            checkOutput("bp_inReady", 128'(inReadyA), 128'd0);
            checkOutput("bp_busy", 128'(busyA), 128'd1);
            @(negedge clk);
        end
        outReadyA = 1'b1;
        #1;
        checkOutput("bp_inReadyThrough", 128'(inReadyA), 128'd1);
        @(negedge clk);
        checkOutput("bp_doneValid", 128'(outValidA), 128'd0);
        checkOutput("bp_doneBusy", 128'(busyA), 128'd0);
        checkOutput("bp_doneOut", outA, 128'd0);

        // Back-to-back: in_valid and out_ready held high for four blocks.
        acc = 0; outs = 0; cyc = 0;
        while (outs < 4 && cyc < 100) begin
            @(negedge clk);
            if (acc < 4) begin
                inA = bbPt[acc]; inValidA = 1'b1;
            end else begin
                inA = '0; inValidA = 1'b0;
            end
            if (outValidA) begin
                checkOutput("b2b_out", outA, bbCt[outs]);
                outs++;
            end
            if (inValidA && inReadyA) begin
                accAt[acc] = cyc;
                acc++;
            end
            cyc++;
        end
        inValidA = 1'b0;
        checkOutput("b2b_outCount", 128'(outs), 128'd4);
        checkOutput("b2b_accCount", 128'(acc), 128'd4);
        for (int i = 0; i < 3; i++)
            checkOutput("b2b_spacing", 128'(accAt[i+1] - accAt[i]), 128'd11);
        @(negedge clk);
        checkOutput("b2b_noDup", 128'(outValidA), 128'd0);

        // Reset while round 5 is in flight, then a clean block.
        @(negedge clk);
        inA = PT_APPB; inValidA = 1'b1;
        @(negedge clk);
        inValidA = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("abort_outValid", 128'(outValidA), 128'd0);
        checkOutput("abort_out", outA, 128'd0);
        checkOutput("abort_busy", 128'(busyA), 128'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abort_inReady", 128'(inReadyA), 128'd1);
        checkOutput("abort_noPulse", 128'(outValidA), 128'd0);
        applyStimulus(PT_APPB, CT_APPB, 1'b0, "afterAbort");

        applyStimulus(PT_APPB, CT_APPB, 1'b1, "noise");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
